// File: rtl/motor_pwm_driver_pkg.sv
// Shared types and constants for the motor PWM channel.
package motor_pkg;

    localparam int SPEED_W   = 8;
    localparam int PWM_STEPS = 255;
    // Last value of the period counter; pcnt runs 0..PCNT_MAX.
    localparam int PCNT_MAX  = PWM_STEPS - 1;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        RUN      = 2'd1,
        FAILSAFE = 2'd2
    } motorState_e;

    // Next duty at a period boundary. Acceleration is limited to step per period.
    // The sum is 9 bits wide, so it cannot wrap. Deceleration jumps straight to the target.
    function automatic logic [SPEED_W-1:0] rampDuty(
        input logic [SPEED_W-1:0] duty,
        input logic [SPEED_W-1:0] target,
        input logic [SPEED_W:0]   step
    );
        logic [SPEED_W:0] sum;
        sum = {1'b0, duty} + step;
        if (target > duty)
            rampDuty = ({1'b0, target} < sum) ? target : sum[SPEED_W-1:0];
        else
            rampDuty = target;
    endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Speed-stage to PWM-driver connection: speed request in, drive status out.
interface motor_pwm_driver_if;
    import motor_pkg::*;

    logic [SPEED_W-1:0] speed_in;
    logic               speed_valid;
    logic               arm;
    logic               pwm_out;
    logic [SPEED_W-1:0] duty_active;
    logic               failsafe;

    // Upstream side: the speed stage / controller.
    modport master (
        output speed_in, speed_valid, arm,
        input  pwm_out, duty_active, failsafe
    );

    // Driver side.
    modport slave (
        input  speed_in, speed_valid, arm,
        output pwm_out, duty_active, failsafe
    );

endinterface

// File: rtl/motor_pwm_driver_pwm_tick_gen.sv
// Prescaler plus 255-step period counter. It can be shared by several motor channels.
module pwm_tick_gen
    import motor_pkg::*;
#(
    parameter int PWM_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               tick,
    output logic [SPEED_W-1:0] pcnt,
    output logic               boundary
);

    localparam int                DIV_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PWM_DIV - 1);
    localparam logic [SPEED_W-1:0] P_LAST  = SPEED_W'(PCNT_MAX);

    logic [DIV_W-1:0] divCnt;

    assign tick     = (divCnt == DIV_LAST);
    assign boundary = tick && (pcnt == P_LAST);

    // Prescaler counts 0..PWM_DIV-1. The period counter steps once per tick and wraps after 254.
    always_ff @(posedge clk) begin
        if (rst) begin
            divCnt <= '0;
            pcnt   <= '0;
        end else begin
            divCnt <= tick ? '0 : divCnt + DIV_W'(1);
            if (tick)
                pcnt <= (pcnt == P_LAST) ? '0 : pcnt + SPEED_W'(1);
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// Single-channel motor PWM driver.
// It ramp-limits acceleration, gates the drive with arm, and
// forces the motor to zero when speed updates stop arriving.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int PWM_DIV         = 4,
    parameter int RAMP_STEP       = 8,
    parameter int TIMEOUT_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rst,
    motor_pwm_driver_if.slave   bus
);

    localparam logic [SPEED_W:0] STEP   = (SPEED_W + 1)'(RAMP_STEP);
    localparam logic [16:0]      TO_LIM = 17'(TIMEOUT_PERIODS);

    motorState_e        state, stateNext;
    logic [SPEED_W-1:0] duty, dutyNext;
    logic [SPEED_W-1:0] target;
    logic [15:0]        toCnt, toNext;
    logic               pwmQ;

    logic               tick;
    logic               boundary;
    logic               periodEnd;
    logic [SPEED_W-1:0] pcnt;
    logic               toExpire;

    pwm_tick_gen #(.PWM_DIV(PWM_DIV)) uTick (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .pcnt     (pcnt),
        .boundary (boundary)
    );

    // boundary is always a qualified tick. Gating it again keeps the driver
    // correct if a generator without that guarantee is dropped in.
    assign periodEnd = tick & boundary;

    // This boundary would bring the silent-period count up to the limit.
    assign toExpire = ({1'b0, toCnt} + 17'd1) >= TO_LIM;

    // Latch the requested speed. The last strobe before a boundary wins.
    always_ff @(posedge clk) begin
        if (rst)
            target <= '0;
        else if (bus.speed_valid)
            target <= bus.speed_in;
    end

    // State, duty and timeout registers, plus the registered PWM compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DISARMED;
            duty  <= '0;
            toCnt <= '0;
            pwmQ  <= 1'b0;
        end else begin
            state <= stateNext;
            duty  <= dutyNext;
            toCnt <= toNext;
            pwmQ  <= (state != DISARMED) && (pcnt < duty);
        end
    end

    // Next-state logic. Losing arm overrides everything and drops duty immediately.
    // In RUN, a speed strobe takes priority over a timeout expiring in the same cycle.
    always_comb begin
        stateNext = state;
        dutyNext  = duty;
        toNext    = toCnt;
        if (!bus.arm) begin
            stateNext = DISARMED;
            dutyNext  = '0;
            toNext    = '0;
        end else begin
            unique case (state)
                DISARMED: begin
                    dutyNext  = '0;
                    toNext    = '0;
                    stateNext = RUN;
                end
                RUN: begin
                    // The boundary uses the target latched before this cycle,
                    // so a strobe landing on the boundary applies one period later.
                    if (periodEnd)
                        dutyNext = rampDuty(duty, target, STEP);
                    if (bus.speed_valid)
                        toNext = '0;
                    else if (periodEnd) begin
                        toNext = (toCnt == 16'hFFFF) ? toCnt : toCnt + 16'd1;
                        if (toExpire)
                            stateNext = FAILSAFE;
                    end
                end
                FAILSAFE: begin
                    // Recovery restarts the ramp from zero, not from the last duty.
                    if (bus.speed_valid) begin
                        stateNext = RUN;
                        toNext    = '0;
                        dutyNext  = '0;
                    end else if (periodEnd) begin
                        dutyNext  = '0;
                    end
                end
                default: begin
                    stateNext = DISARMED;
                    dutyNext  = '0;
                    toNext    = '0;
                end
            endcase
        end
    end

    assign bus.pwm_out     = pwmQ;
    assign bus.duty_active = duty;
    assign bus.failsafe    = (state == FAILSAFE);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver.
// dut1 uses RAMP_STEP=16 and covers ramp, deceleration, timeout and reset.
// dut2 uses RAMP_STEP=255 and covers the duty extremes and arm drop.
// Both instances receive identical stimulus.
module tb_motor_pwm_driver;
    import motor_pkg::*;

    localparam int PERIOD = 510;  // 255 ticks * PWM_DIV 2

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] speedIn = '0;
    logic       speedValid = 1'b0;
    logic       arm = 1'b0;

    int errors = 0;
    int checks = 0;
    int hi1, hi2;

    motor_pwm_driver_if bus1 ();
    motor_pwm_driver_if bus2 ();

    assign bus1.speed_in    = speedIn;
    assign bus1.speed_valid = speedValid;
    assign bus1.arm         = arm;
    assign bus2.speed_in    = speedIn;
    assign bus2.speed_valid = speedValid;
    assign bus2.arm         = arm;

    motor_pwm_driver #(.PWM_DIV(2), .RAMP_STEP(16), .TIMEOUT_PERIODS(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    motor_pwm_driver #(.PWM_DIV(2), .RAMP_STEP(255), .TIMEOUT_PERIODS(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Run one PWM period, starting in its first cycle. Optionally strobe a speed
    // at cycle offset off. Count pwm_out-high samples over the next 510 cycles,
    // which is exactly the output produced by this period's duty.
    task automatic period(input bit sv, input int off, input logic [7:0] spd);
        hi1 = 0;
        hi2 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (sv && i == off) begin
                speedIn    = spd;
                speedValid = 1'b1;
            end
            clk1();
            speedValid = 1'b0;
            hi1 += int'(bus1.pwm_out);
            hi2 += int'(bus2.pwm_out);
        end
    endtask

    initial begin
        int expD;
        int prevD;

        // Reset state
        repeat (3) clk1();
        chk("rst_pwm1",  bus1.pwm_out, 0);
        chk("rst_duty1", bus1.duty_active, 0);
        chk("rst_fs1",   bus1.failsafe, 0);
        chk("rst_pwm2",  bus2.pwm_out, 0);
        chk("rst_duty2", bus2.duty_active, 0);
        rst = 1'b0;
        arm = 1'b1;

        // Ramp-up to 200 in steps of 16, then hold
        prevD = 0;
        for (int p = 0; p < 14; p++) begin
            period(1'b1, 100, 8'd200);
            expD = (16 * (p + 1) < 200) ? 16 * (p + 1) : 200;
            chk($sformatf("ramp_hi[%0d]", p), hi1, 2 * prevD);
            chk($sformatf("ramp_duty[%0d]", p), bus1.duty_active, expD);
            prevD = expD;
        end
        chk("ramp_fs", bus1.failsafe, 0);

        // Deceleration is immediate
        period(1'b1, 100, 8'd40);
        chk("decel_hi", hi1, 400);
        chk("decel_duty", bus1.duty_active, 40);

        // Timeout: the last strobe was in the previous period.
        // The fourth boundary without a strobe expires.
        period(1'b0, 0, 8'd0);
        chk("to_fs_a", bus1.failsafe, 0);
        chk("to_hi_a", hi1, 80);
        period(1'b0, 0, 8'd0);
        chk("to_fs_b", bus1.failsafe, 0);
        period(1'b0, 0, 8'd0);
        chk("to_fs_set", bus1.failsafe, 1);
        chk("to_duty_kept", bus1.duty_active, 40);
        period(1'b0, 0, 8'd0);
        chk("fs_hi", hi1, 80);
        chk("fs_duty0", bus1.duty_active, 0);
        chk("fs_hold", bus1.failsafe, 1);

        // Recovery with speed 100 restarts the ramp from 0
        period(1'b1, 100, 8'd100);
        chk("rec_fs", bus1.failsafe, 0);
        chk("rec_duty", bus1.duty_active, 16);
        chk("rec_hi", hi1, 0);
        period(1'b1, 100, 8'd100);
        chk("rec_duty2", bus1.duty_active, 32);
        period(1'b0, 0, 8'd0);
        chk("rec_duty3", bus1.duty_active, 48);
        period(1'b0, 0, 8'd0);
        chk("rec_duty4", bus1.duty_active, 64);

        // A strobe on the expiring boundary beats the timeout.
        // That boundary still uses the old target (100), so ramp to 80;
        // the new target 30 applies one period later.
        period(1'b1, PERIOD - 1, 8'd30);
        chk("sim_fs", bus1.failsafe, 0);
        chk("sim_old_target", bus1.duty_active, 80);
        period(1'b0, 0, 8'd0);
        chk("sim_new_target", bus1.duty_active, 30);
        chk("sim_fs2", bus1.failsafe, 0);

        // rst mid-ramp
        period(1'b1, 100, 8'd128);
        chk("mr_duty", bus1.duty_active, 46);
        repeat (50) clk1();
        chk("mr_pwm_hi", bus1.pwm_out, 1);
        rst = 1'b1;
        clk1();
        chk("mr_rst_pwm", bus1.pwm_out, 0);
        chk("mr_rst_duty", bus1.duty_active, 0);
        chk("mr_rst_fs", bus1.failsafe, 0);
        chk("mr_rst_state", dut1.state, DISARMED);
        rst = 1'b0;
        arm = 1'b1;

        // Extremes on dut2: full speed in one boundary gives constant high
        period(1'b1, 100, 8'd255);
        chk("x255_duty", bus2.duty_active, 255);
        period(1'b1, 100, 8'd255);
        chk("x255_hi", hi2, PERIOD);
        period(1'b1, 100, 8'd0);
        chk("x255_hi2", hi2, PERIOD);
        chk("x0_duty", bus2.duty_active, 0);
        period(1'b1, 100, 8'd0);
        chk("x0_hi", hi2, 0);

        // Arm drop mid-period at duty 128
        period(1'b1, 100, 8'd128);
        chk("arm_duty128", bus2.duty_active, 128);
        repeat (20) clk1();
        chk("arm_pwm_pre", bus2.pwm_out, 1);
        arm = 1'b0;
        clk1();
        chk("arm_duty0", bus2.duty_active, 0);
        chk("arm_state", dut2.state, DISARMED);
        chk("arm_fs", bus2.failsafe, 0);
        clk1();
        chk("arm_pwm0", bus2.pwm_out, 0);
        repeat (10) clk1();
        chk("arm_pwm_stay0", bus2.pwm_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Converts the 8-bit motor speed produced by the DShot speed stage into a glitch-free PWM drive signal for one motor channel. It sits directly downstream of the speed stage and consumes its `outputSpeed` value plus an update strobe. It applies an acceleration ramp limit, an arm gate, and a signal-loss failsafe that forces the motor to zero when speed updates stop arriving.

## Interface
- `PWM_DIV`, default 4: clock cycles per PWM counter step (≥1).
- `RAMP_STEP`, default 8: maximum duty increase per PWM period (1..255).
- `TIMEOUT_PERIODS`, default 64: PWM periods without `speed_valid` before failsafe (1..65535).

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `speed_in`  in  8  requested speed, 0 = stop, 255 = full.
- `speed_valid`  in  1  one-cycle strobe; `speed_in` is valid this cycle.
- `arm`  in  1  level; low disables drive.
- `pwm_out`  out  1  registered PWM drive.
- `duty_active`  out  8  duty currently applied.
- `failsafe`  out  1  high while in FAILSAFE.

## Operation
- **Prescaler:** `div_cnt` counts 0..PWM_DIV-1. `tick` is asserted when `div_cnt == PWM_DIV-1`.
- **Period counter:** `pcnt` advances on `tick` over 0..254 and wraps to 0. One period is 255 ticks, i.e. 255·PWM_DIV clocks. The **boundary** is a `tick` with `pcnt == 254`.
- **Target capture:** on `speed_valid`, `target <= speed_in`. The last write in a period is the one that wins.
- **States:**
  - **DISARMED:** `duty_active` forced to 0 and `pwm_out` held 0. Moves to RUN when `arm == 1`; the timeout counter is cleared on entry.
  - **RUN:** at each boundary the duty is updated:
    - if `target > duty_active`: `duty_active <= min(target, duty_active + RAMP_STEP)`, computed in 9 bits and saturating at 255;
    - otherwise: `duty_active <= target`, so deceleration is immediate.
    - The timeout counter increments at each boundary and clears on `speed_valid`. When it reaches TIMEOUT_PERIODS the state moves to FAILSAFE.
  - **FAILSAFE:** `failsafe = 1`; `duty_active` is set to 0 at the next boundary. A `speed_valid` moves the state back to RUN and clears the counter; ramp-up then restarts from 0.
  - From any state, `arm == 0` moves to DISARMED in the next cycle, with `duty_active <= 0` immediately, not waiting for a boundary.
- **PWM compare:** `pwm_out <= (state != DISARMED) && (pcnt < duty_active)`.
  - duty 0 gives constant low.
  - duty 255 gives constant high, since `pcnt` never reaches 255.
- **Simultaneous events:**
  - `speed_valid` in the same cycle as the timeout expiry: `speed_valid` wins, the counter clears, and FAILSAFE is not entered.
  - `speed_valid` on a boundary cycle: the boundary uses the old `target`; the new value applies at the next boundary.
  - `arm` falling on a boundary: DISARMED wins.
- The timeout counter saturates and never wraps.

## Timing
- **Reset values:** `pwm_out = 0`, `duty_active = 0`, `failsafe = 0`, state DISARMED, `target = 0`, all counters 0.
- **`rst` mid-operation:** returns every register to its reset value on the same edge, including a mid-ramp duty.
- **Latency:**
  - `pwm_out` reflects the `pcnt`/`duty_active` compare one clock later.
  - A new duty becomes visible on `duty_active` the cycle after the boundary.
- **Worst-case update delay:** from `speed_valid` to the first period using the new target is one full period plus 1 clock.
- **`arm` falling:** `pwm_out` is 0 within 2 clocks.
- **Failsafe assertion:** `failsafe` asserts the cycle after the expiring boundary.

## Structure
- Shared package `motor_pkg`:
  - state enum: DISARMED, RUN, FAILSAFE;
  - `PWM_STEPS = 255`;
  - width constant `SPEED_W = 8`.
- Sub-module `pwm_tick_gen`: prescaler plus period counter, with outputs `tick`, `pcnt` and `boundary`. It is reusable across motor channels.
- The ramp, timeout and state machine stay in `motor_pwm_driver`.

## Test plan
All scenarios use PWM_DIV=2, RAMP_STEP=16, TIMEOUT_PERIODS=4 unless stated.
- **Ramp-up:** reset, `arm=1`, `speed_valid` with `speed_in=200` → `duty_active` sequence at boundaries is 16, 32, …, 192, 200, then holds. `pwm_out` is high for exactly `duty_active`·2 clocks per 510-clock period.
- **Deceleration:** at duty 200, `speed_in=40` → `duty_active = 40` at the next boundary, with no ramp.
- **Timeout:** no `speed_valid` for 4 periods → `failsafe=1`, and `duty_active=0` at the following boundary. A `speed_valid` with value 100 → `failsafe=0` and the ramp restarts at 16.
- **Extremes:**
  - `speed_in=255` with RAMP_STEP=255 → `pwm_out` constantly high after one boundary;
  - `speed_in=0` → `pwm_out` never high.
- **Arm drop and reset:**
  - `arm` falling mid-period at duty 128 → `pwm_out=0` within 2 clocks, `duty_active=0`, state DISARMED.
  - `rst` pulse mid-ramp → all outputs return to 0.
- **Simultaneous events:** `speed_valid` on the expiring-boundary cycle → `failsafe` stays 0.
